// File: rtl/ps2_key_cmd_ctrl_if.sv
// Byte-stream input and command valid/ready output bundle for the PS/2 command sequencer.
// The master side drives bytes and consumes commands; the slave side is the sequencer.
interface ps2_key_cmd_ctrl_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_code;
  logic       cmd_repeat;

  modport master (
    output byte_valid, byte_data, cmd_ready,
    input  cmd_valid, cmd_code, cmd_repeat
  );

  modport slave (
    input  byte_valid, byte_data, cmd_ready,
    output cmd_valid, cmd_code, cmd_repeat
  );
endinterface

// File: rtl/ps2_key_cmd_ctrl.sv
// PS/2 scancode parser: make/break/E0 decoding, held-key tracking, movement auto-repeat,
// and a small command FIFO drained through a valid/ready handshake.
module ps2_key_cmd_ctrl #(
  parameter int REPEAT_DLY = 6000000,
  parameter int REPEAT_PER = 1200000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  ps2_key_cmd_ctrl_if.slave     bus,
  output logic [5:0]            held,
  output logic                  overflow
);
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW   = $clog2(RMAX + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK} state_e;
  typedef struct packed {
    logic       rep;
    logic [2:0] code;
  } entry_t;

  // {hit, code}; unmapped pairs return hit=0
  function automatic logic [3:0] key_map(input logic ext, input logic [7:0] b);
    logic [3:0] r;
    r = 4'b0000;
    if (ext) begin
      case (b)
        8'h75:   r = {1'b1, 3'd0};
        8'h72:   r = {1'b1, 3'd1};
        8'h6B:   r = {1'b1, 3'd2};
        8'h74:   r = {1'b1, 3'd3};
        8'h5A:   r = {1'b1, 3'd4};
        default: r = 4'b0000;
      endcase
    end else begin
      case (b)
        8'h1D, 8'h75: r = {1'b1, 3'd0};
        8'h1B, 8'h72: r = {1'b1, 3'd1};
        8'h1C, 8'h6B: r = {1'b1, 3'd2};
        8'h23, 8'h74: r = {1'b1, 3'd3};
        8'h3B, 8'h5A: r = {1'b1, 3'd4};
        8'h42, 8'h76: r = {1'b1, 3'd5};
        default:      r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  // parser state
  state_e state_q, state_d;
  logic   ext_q, ext_d;
  logic   mk_ev, bk_ev, key_ext;

  // key / repeat state
  logic [5:0]    held_q, held_d;
  logic          arm_q, arm_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          make_push, rep_push;

  // fifo state
  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [NW-1:0] cnt_q;
  logic          ovf_q;

  logic [3:0]  km;
  logic        hit;
  logic [2:0]  kc;
  logic        full, pop, push_req, push_ok;
  entry_t      push_entry;

  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    mk_ev   = 1'b0;
    bk_ev   = 1'b0;
    key_ext = 1'b0;
    if (bus.byte_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.byte_data == 8'hE0) begin
            state_d = EXT;
          end else if (bus.byte_data == 8'hF0) begin
            state_d = BRK;
            ext_d   = 1'b0;
          end else begin
            mk_ev = 1'b1;
          end
        end
        EXT: begin
          if (bus.byte_data == 8'hF0) begin
            state_d = BRK;
            ext_d   = 1'b1;
          end else if (bus.byte_data != 8'hE0) begin
            mk_ev   = 1'b1;
            key_ext = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          state_d = IDLE;
          // a second prefix inside a break is malformed and dropped
          if (bus.byte_data != 8'hE0 && bus.byte_data != 8'hF0) begin
            bk_ev   = 1'b1;
            key_ext = ext_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign km  = key_map(key_ext, bus.byte_data);
  assign hit = km[3];
  assign kc  = km[2:0];

  always_comb begin
    held_d    = held_q;
    arm_d     = arm_q;
    sel_d     = sel_q;
    rcnt_d    = rcnt_q;
    make_push = 1'b0;
    rep_push  = 1'b0;
    if (arm_q) begin
      if (rcnt_q == CW'(1)) begin
        rep_push = 1'b1;
        rcnt_d   = CW'(REPEAT_PER);
      end else begin
        rcnt_d = rcnt_q - CW'(1);
      end
    end
    // typematic re-makes of a held key are swallowed here
    if (mk_ev && hit && !held_q[kc]) begin
      held_d[kc] = 1'b1;
      make_push  = 1'b1;
      if (kc <= 3'd3) begin
        arm_d  = 1'b1;
        sel_d  = kc[1:0];
        rcnt_d = CW'(REPEAT_DLY);
      end
    end
    if (bk_ev && hit) begin
      held_d[kc] = 1'b0;
      if (arm_q && kc == {1'b0, sel_q}) arm_d = 1'b0;
    end
  end

  assign full       = (cnt_q == NW'(FIFO_DEPTH));
  assign pop        = (cnt_q != '0) && bus.cmd_ready;
  assign push_req   = make_push || rep_push;
  assign push_ok    = push_req && (!full || pop);
  assign push_entry = make_push ? entry_t'{rep: 1'b0, code: kc}
                                : entry_t'{rep: 1'b1, code: {1'b0, sel_q}};

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      ext_q   <= 1'b0;
      held_q  <= '0;
      arm_q   <= 1'b0;
      sel_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      held_q  <= held_d;
      arm_q   <= arm_d;
      sel_q   <= sel_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_entry;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + NW'(1);
        2'b01:   cnt_q <= cnt_q - NW'(1);
        default: cnt_q <= cnt_q;
      endcase
      // only a lost make is worth flagging; lost repeats are expected under backpressure
      if (make_push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign bus.cmd_valid  = (cnt_q != '0);
  assign bus.cmd_code   = mem_q[rd_q].code;
  assign bus.cmd_repeat = mem_q[rd_q].rep;
  assign held           = held_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_ps2_key_cmd_ctrl.sv
// Scoreboard bench for ps2_key_cmd_ctrl with short repeat timing (20/8 cycles).
module tb_ps2_key_cmd_ctrl;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic [5:0] held;
  logic overflow;
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0] code;
    logic       rep;
    int         cyc;   // expected visible cycle, -1 when timing is not checked
  } exp_t;
  exp_t q[$];

  ps2_key_cmd_ctrl_if bus();

  ps2_key_cmd_ctrl #(.REPEAT_DLY(20), .REPEAT_PER(8), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus), .held(held), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // consumer side: every handshake must match the scoreboard head
  always @(negedge clk_in) begin
    if (rst_n_in && bus.cmd_valid && bus.cmd_ready) begin
      exp_t e;
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_cmd: got code=%0d rep=%0d at cyc %0d, expected none",
                 bus.cmd_code, bus.cmd_repeat, cyc);
      end else begin
        e = q.pop_front();
        if (bus.cmd_code !== e.code || bus.cmd_repeat !== e.rep || (e.cyc >= 0 && e.cyc != cyc))
          $display("FAIL scoreboard: got code=%0d rep=%0d cyc=%0d, expected code=%0d rep=%0d cyc=%0d",
                   bus.cmd_code, bus.cmd_repeat, cyc, e.code, e.rep, e.cyc);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int cap);
    tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    cap = cyc + 1;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int c;
    send_byte(b, c);
  endtask

  task automatic push_exp(input logic [2:0] code, input logic rep, input int c);
    exp_t e;
    e.code = code; e.rep = rep; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic pulse_reset();
    tick();
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
  endtask

  task automatic test_reset();
    bus.cmd_ready = 1'b0;
    pulse_reset();
    n_total++;
    if ({bus.cmd_valid, bus.cmd_code, bus.cmd_repeat, held, overflow} !== 12'd0)
      $display("FAIL reset_state: got valid=%b code=%0d rep=%b held=%b ovf=%b, expected all 0",
               bus.cmd_valid, bus.cmd_code, bus.cmd_repeat, held, overflow);
    else n_pass++;
  endtask

  task automatic test_single_make();
    int c;
    pulse_reset();
    bus.cmd_ready = 1'b1;
    send_byte(8'h1D, c);
    push_exp(3'd0, 1'b0, c);
    n_total++;
    if (held !== 6'b000001) $display("FAIL make_held: got %b, expected 000001", held);
    else n_pass++;
    n_total++;
    if (bus.cmd_valid !== 1'b1) $display("FAIL make_valid: got %b, expected 1", bus.cmd_valid);
    else n_pass++;
    tick();
    n_total++;
    if (bus.cmd_valid !== 1'b0) $display("FAIL make_pulse: got valid %b, expected 0", bus.cmd_valid);
    else n_pass++;
    send(8'hF0); send(8'h1D);
    n_total++;
    if (held !== 6'b0) $display("FAIL break_held: got %b, expected 000000", held);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_repeat_timing();
    int m;
    pulse_reset();
    bus.cmd_ready = 1'b1;
    send(8'hE0);
    send_byte(8'h6B, m);
    push_exp(3'd2, 1'b0, m);
    push_exp(3'd2, 1'b1, m + 20);
    push_exp(3'd2, 1'b1, m + 28);
    push_exp(3'd2, 1'b1, m + 36);
    n_total++;
    if (held !== 6'b000100) $display("FAIL ext_make_held: got %b, expected 000100", held);
    else n_pass++;
    while (cyc < m + 30) begin
      send(8'hE0); send(8'h6B); tick();
    end
    while (cyc < m + 37) tick();
    send(8'hE0); send(8'hF0); send(8'h6B);
    repeat (30) tick();
    n_total++;
    if (held !== 6'b0) $display("FAIL ext_break_held: got %b, expected 000000", held);
    else n_pass++;
    n_total++;
    if (q.size() != 0) $display("FAIL repeat_missing: got %0d pending, expected 0", q.size());
    else n_pass++;
  endtask

  task automatic test_break_malformed();
    int c;
    pulse_reset();
    bus.cmd_ready = 1'b1;
    send(8'hF0); send(8'h1D);
    repeat (3) tick();
    n_total++;
    if (bus.cmd_valid !== 1'b0 || held !== 6'b0)
      $display("FAIL unheld_break: got valid=%b held=%b, expected 0/000000", bus.cmd_valid, held);
    else n_pass++;
    send(8'hE0); send(8'hF0); send(8'hE0);
    send_byte(8'h1C, c);
    push_exp(3'd2, 1'b0, c);
    n_total++;
    if (held !== 6'b000100) $display("FAIL malformed_held: got %b, expected 000100", held);
    else n_pass++;
    send(8'hF0); send(8'h1C);
    wait_drain();
    n_total++;
    if (q.size() != 0) $display("FAIL malformed_drain: got %0d pending, expected 0", q.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    pulse_reset();
    bus.cmd_ready = 1'b0;
    send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23); send(8'h3B);
    for (int i = 0; i < 4; i++) push_exp(3'(i), 1'b0, -1);
    n_total++;
    if (overflow !== 1'b1 || bus.cmd_valid !== 1'b1 || bus.cmd_code !== 3'd0)
      $display("FAIL overflow_full: got ovf=%b valid=%b code=%0d, expected 1/1/0",
               overflow, bus.cmd_valid, bus.cmd_code);
    else n_pass++;
    bus.cmd_ready = 1'b1;
    send(8'hF0); send(8'h23);
    wait_drain();
    n_total++;
    if (q.size() != 0 || overflow !== 1'b1)
      $display("FAIL overflow_sticky: got pending=%0d ovf=%b, expected 0/1", q.size(), overflow);
    else n_pass++;
    repeat (25) tick();
    pulse_reset();
    n_total++;
    if (overflow !== 1'b0) $display("FAIL overflow_reset: got %b, expected 0", overflow);
    else n_pass++;
  endtask

  task automatic test_repeat_owner();
    int u, d, a;
    pulse_reset();
    bus.cmd_ready = 1'b1;
    send_byte(8'h1D, u);
    push_exp(3'd0, 1'b0, u);
    send_byte(8'h23, d);
    push_exp(3'd3, 1'b0, d);
    push_exp(3'd3, 1'b1, d + 20);
    push_exp(3'd3, 1'b1, d + 28);
    while (cyc < d + 29) tick();
    send(8'hF0); send(8'h23);
    repeat (30) tick();
    n_total++;
    if (held !== 6'b000001 || q.size() != 0)
      $display("FAIL owner_switch: got held=%b pending=%0d, expected 000001/0", held, q.size());
    else n_pass++;
    pulse_reset();
    send_byte(8'h1D, u);
    push_exp(3'd0, 1'b0, u);
    send_byte(8'h3B, a);
    push_exp(3'd4, 1'b0, a);
    push_exp(3'd0, 1'b1, u + 20);
    while (cyc < u + 21) tick();
    send(8'hF0); send(8'h1D);
    repeat (20) tick();
    n_total++;
    if (held !== 6'b010000 || q.size() != 0)
      $display("FAIL action_no_touch: got held=%b pending=%0d, expected 010000/0", held, q.size());
    else n_pass++;
  endtask

  task automatic test_reset_prefix();
    int c;
    pulse_reset();
    bus.cmd_ready = 1'b0;
    send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23); send(8'h3B);
    send(8'hE0);
    pulse_reset();
    n_total++;
    if (held !== 6'b0 || overflow !== 1'b0 || bus.cmd_valid !== 1'b0)
      $display("FAIL midreset_clear: got held=%b ovf=%b valid=%b, expected 0", held, overflow, bus.cmd_valid);
    else n_pass++;
    bus.cmd_ready = 1'b1;
    send_byte(8'h75, c);
    push_exp(3'd0, 1'b0, c);
    n_total++;
    if (held !== 6'b000001) $display("FAIL midreset_75: got held=%b, expected 000001", held);
    else n_pass++;
    send(8'hF0); send(8'h75);
    send(8'hE0);
    pulse_reset();
    // E0 1D would be unmapped, so UP here proves the prefix was dropped
    send_byte(8'h1D, c);
    push_exp(3'd0, 1'b0, c);
    send(8'hF0); send(8'h1D);
    wait_drain();
    n_total++;
    if (q.size() != 0) $display("FAIL midreset_prefix: got %0d pending, expected 0", q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    bus.cmd_ready = 1'b0;
    send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23);
    for (int i = 0; i < 5; i++) push_exp(3'(i), 1'b0, -1);
    tick();
    bus.cmd_ready  = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h3B;
    tick();
    bus.cmd_ready  = 1'b0;
    bus.byte_valid = 1'b0;
    n_total++;
    if (overflow !== 1'b0 || bus.cmd_valid !== 1'b1 || bus.cmd_code !== 3'd1)
      $display("FAIL push_pop_full: got ovf=%b valid=%b code=%0d, expected 0/1/1",
               overflow, bus.cmd_valid, bus.cmd_code);
    else n_pass++;
    send(8'hF0); send(8'h23);
    bus.cmd_ready = 1'b1;
    wait_drain();
    tick();
    n_total++;
    if (q.size() != 0 || bus.cmd_valid !== 1'b0)
      $display("FAIL push_pop_drain: got pending=%0d valid=%b, expected 0/0", q.size(), bus.cmd_valid);
    else n_pass++;
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.cmd_ready  = 1'b0;
    test_reset();
    test_single_make();
    test_repeat_timing();
    test_break_malformed();
    test_overflow();
    test_repeat_owner();
    test_reset_prefix();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cyc %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
